// File: rtl/led7_scan_decoder.sv
// Recovers the four BCD digits shown on a multiplexed, active-low 7-segment display
// by watching its anode/segment lines, and publishes each complete scan as one frame.
module led7_scan_decoder #(
    parameter int SETTLE  = 4,
    parameter int TIMEOUT = 1000
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic [3:0]  led7_an_i,
    input  logic [7:0]  led7_seg_i,
    output logic [15:0] digits_o,
    output logic [3:0]  dp_o,
    output logic [3:0]  blank_o,
    output logic        valid_o,
    output logic        err_o,
    output logic        frame_o
);

    localparam int SW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE - 1);
    localparam logic [TW-1:0] TO_LAST     = TW'(TIMEOUT - 1);

    typedef enum logic [1:0] {ST_IDLE, ST_SETTLE, ST_HOLD} state_t;

    state_t          state_q;
    logic [3:0]      an_q;
    logic [7:0]      seg_q;
    logic [3:0]      cur_an_q;
    logic [SW-1:0]   set_cnt_q;
    logic [TW-1:0]   to_cnt_q;
    logic [3:0]      seen_q;
    logic [3:0]      slot_err_q;
    logic [3:0]      slot_dp_q;
    logic [3:0]      slot_blank_q;
    logic [3:0]      slot_digit_q [4];
    logic [15:0]     slot_digits_flat;

    logic            an_onehot_d;
    logic            an_changed_d;
    logic            capture_d;
    logic            publish_d;
    logic            stale_d;
    logic [1:0]      cur_idx_d;
    logic [3:0]      dec_digit_d;
    logic            dec_blank_d;
    logic            dec_err_d;

    function automatic logic [1:0] idx_of(input logic [3:0] an);
        logic [1:0] idx;
        idx = 2'd0;
        case (an)
            4'b1101: idx = 2'd1;
            4'b1011: idx = 2'd2;
            4'b0111: idx = 2'd3;
            default: idx = 2'd0;
        endcase
        return idx;
    endfunction

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_pack
            assign slot_digits_flat[4*gi +: 4] = slot_digit_q[gi];
        end
    endgenerate

    always_comb begin
        an_onehot_d = 1'b0;
        case (an_q)
            4'b1110, 4'b1101, 4'b1011, 4'b0111: an_onehot_d = 1'b1;
            default:                            an_onehot_d = 1'b0;
        endcase
        an_changed_d = (an_q != cur_an_q);
        capture_d    = (state_q == ST_SETTLE) && !an_changed_d && (set_cnt_q == SETTLE_LAST);
        publish_d    = (seen_q == 4'hF);
        stale_d      = (to_cnt_q == TO_LAST);
        cur_idx_d    = idx_of(cur_an_q);
    end

    // Segment pattern (gfedcba, active-low) to BCD; 7F is a dark digit.
    always_comb begin
        dec_digit_d = 4'hE;
        dec_blank_d = 1'b0;
        dec_err_d   = 1'b0;
        case (seg_q[6:0])
            7'h40: dec_digit_d = 4'd0;
            7'h79: dec_digit_d = 4'd1;
            7'h24: dec_digit_d = 4'd2;
            7'h30: dec_digit_d = 4'd3;
            7'h19: dec_digit_d = 4'd4;
            7'h12: dec_digit_d = 4'd5;
            7'h02: dec_digit_d = 4'd6;
            7'h78: dec_digit_d = 4'd7;
            7'h00: dec_digit_d = 4'd8;
            7'h10: dec_digit_d = 4'd9;
            7'h7F: begin
                dec_digit_d = 4'hF;
                dec_blank_d = 1'b1;
            end
            default: dec_err_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= ST_IDLE;
            an_q         <= 4'hF;
            seg_q        <= 8'hFF;
            cur_an_q     <= 4'hF;
            set_cnt_q    <= '0;
            to_cnt_q     <= '0;
            seen_q       <= 4'h0;
            slot_err_q   <= 4'h0;
            slot_dp_q    <= 4'h0;
            slot_blank_q <= 4'hF;
            for (int i = 0; i < 4; i++) slot_digit_q[i] <= 4'hF;
            digits_o     <= 16'hFFFF;
            dp_o         <= 4'h0;
            blank_o      <= 4'hF;
            valid_o      <= 1'b0;
            err_o        <= 1'b0;
            frame_o      <= 1'b0;
        end else begin
            an_q    <= led7_an_i;
            seg_q   <= led7_seg_i;
            frame_o <= 1'b0;

            case (state_q)
                ST_IDLE: begin
                    if (an_onehot_d) begin
                        state_q   <= ST_SETTLE;
                        cur_an_q  <= an_q;
                        set_cnt_q <= '0;
                    end
                end
                ST_SETTLE: begin
                    if (an_changed_d) begin
                        cur_an_q  <= an_q;
                        set_cnt_q <= '0;
                        state_q   <= an_onehot_d ? ST_SETTLE : ST_IDLE;
                    end else if (capture_d) begin
                        state_q <= ST_HOLD;
                    end else begin
                        set_cnt_q <= set_cnt_q + SW'(1);
                    end
                end
                ST_HOLD: begin
                    if (an_changed_d) state_q <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase

            // Publication takes priority over staleness; a capture in the same
            // cycle lands after the clear because its assignments come later.
            if (publish_d) begin
                digits_o   <= slot_digits_flat;
                dp_o       <= slot_dp_q;
                blank_o    <= slot_blank_q;
                err_o      <= |slot_err_q;
                valid_o    <= ~(|slot_err_q);
                frame_o    <= 1'b1;
                seen_q     <= 4'h0;
                slot_err_q <= 4'h0;
            end else if (stale_d) begin
                valid_o    <= 1'b0;
                seen_q     <= 4'h0;
                slot_err_q <= 4'h0;
            end

            if (capture_d) begin
                seen_q[cur_idx_d]       <= 1'b1;
                slot_digit_q[cur_idx_d] <= dec_digit_d;
                slot_blank_q[cur_idx_d] <= dec_blank_d;
                slot_err_q[cur_idx_d]   <= dec_err_d;
                slot_dp_q[cur_idx_d]    <= ~seg_q[7];
            end

            if (capture_d || publish_d) begin
                to_cnt_q <= '0;
            end else if (!stale_d) begin
                to_cnt_q <= to_cnt_q + TW'(1);
            end
        end
    end

endmodule
